// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
// Shared types and constants for the arbitrated ALU sequencer.
//   alu_op_e : 3-bit opcode of the shared ALU datapath
//   state_e  : sequencer FSM state
//   NREQ     : number of requesters sharing the ALU
package alu_arb_pkg;

  localparam int NREQ = 2;
  localparam int OPW  = 3;

  typedef enum logic [OPW-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    NOT = 3'd2,
    AND = 3'd3,
    OR  = 3'd4,
    XOR = 3'd5,
    SLT = 3'd6,
    EQ  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core
// Purely combinational DW-bit ALU. All arithmetic wraps modulo 2^DW.
// Ports:
//   a, b   : operands
//   op     : opcode (alu_op_e encoding)
//   result : arithmetic/logic result (0 for compare ops)
//   flg    : compare flag (0 for arithmetic/logic ops)
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [OPW-1:0] op,
  output logic [DW-1:0]  result,
  output logic           flg
);

  logic [DW-1:0] diff;
  logic          ovf;

  // The subtractor is shared by SUB, SLT and EQ. Signed overflow occurs when
  // the operand signs differ and the difference sign differs from a's sign.
  always_comb begin
    diff   = a + ~b + 1'b1;
    ovf    = (a[DW-1] ^ b[DW-1]) & (diff[DW-1] ^ a[DW-1]);
    result = '0;
    flg    = 1'b0;
    case (alu_op_e'(op))
      ADD:     result = a + b;
      SUB:     result = diff;
      NOT:     result = ~a;
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      SLT:     flg    = diff[DW-1] ^ ovf;
      EQ:      flg    = (diff == '0);
      default: begin
        result = '0;
        flg    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arb_ctrl.sv
// alu_arb_ctrl
// Shares one alu_core between two requesters. A round-robin arbiter picks a
// request in IDLE, the operands are latched, EXEC registers the ALU output and
// RESP presents it to the owning requester until it is accepted.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester issue handshake (bit i = requester i)
//   req_op/req_a/req_b    : packed per-requester opcode and operands
//   rsp_valid/rsp_ready   : per-requester response handshake
//   rsp_result/rsp_flg    : shared registered result and flag
//   busy                  : FSM not in IDLE
//   grant_cnt0/grant_cnt1 : saturating completed-response counters, present
//                           only when ALU_ARB_STATS_EN is defined
module alu_arb_ctrl
  import alu_arb_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [DW-1:0]       rsp_result,
  output logic                rsp_flg,
`ifdef ALU_ARB_STATS_EN
  output logic [7:0]          grant_cnt0,
  output logic [7:0]          grant_cnt1,
`endif
  output logic                busy
);

  state_e         state_q, state_d;
  logic           rr_q, rr_d;
  logic           owner_q, owner_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [DW-1:0]  result_q, result_d;
  logic           flg_q, flg_d;

  logic           grant_vld;
  logic           grant_id;
  logic           rsp_done;
  logic [DW-1:0]  alu_result;
  logic           alu_flg;

  // rr_q names the requester preferred on a tie; a lone valid always wins.
  always_comb begin
    grant_vld = |req_valid;
    grant_id  = (&req_valid) ? rr_q : req_valid[1];
    rsp_done  = (state_q == RESP) && rsp_ready[owner_q];
  end

  alu_core #(.DW(DW)) u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .flg    (alu_flg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is built only from state, rr pointer and req_valid so that no
  // combinational path exists from rsp_ready back to the issue side.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == IDLE && grant_vld) begin
      req_ready = {grant_id, ~grant_id};
    end
    if (state_q == RESP) begin
      rsp_valid = {owner_q, ~owner_q};
    end
    busy       = (state_q != IDLE);
    rsp_result = result_q;
    rsp_flg    = flg_q;
  end

  // The pointer only moves on a completed response, so a reset mid-operation
  // leaves it at its reset value of requester 0.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    owner_d  = owner_q;
    result_d = result_q;
    flg_d    = flg_q;
    rr_d     = rr_q;
    if (state_q == IDLE && grant_vld) begin
      owner_d = grant_id;
      op_d    = grant_id ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
      a_d     = grant_id ? req_a[2*DW-1:DW]    : req_a[DW-1:0];
      b_d     = grant_id ? req_b[2*DW-1:DW]    : req_b[DW-1:0];
    end
    if (state_q == EXEC) begin
      result_d = alu_result;
      flg_d    = alu_flg;
    end
    if (rsp_done) begin
      rr_d = ~owner_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flg_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flg_q    <= flg_d;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0_q, grant_cnt0_d;
  logic [7:0] grant_cnt1_q, grant_cnt1_d;

  // Counters saturate at 255 rather than wrapping.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (rsp_done && !owner_q && grant_cnt0_q != 8'hFF) grant_cnt0_d = grant_cnt0_q + 8'd1;
    if (rsp_done &&  owner_q && grant_cnt1_q != 8'hFF) grant_cnt1_d = grant_cnt1_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// tb_alu_arb_ctrl
// Directed bench for alu_arb_ctrl. Inputs change and outputs are sampled
// around the falling clock edge; the design acts on the rising edge.
// The grant counters are exercised when ALU_ARB_STATS_EN is defined.
module tb_alu_arb_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [5:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_flg;
  logic       busy;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0;
  logic [7:0] grant_cnt1;
`endif

  int checks;
  int failures;
  logic [1:0] expGrant;
  logic [3:0] expResult;

  alu_arb_ctrl #(.DW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flg    (rsp_flg),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .busy       (busy)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the sequence below ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [5:0] op,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] rr);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete transaction with the owner accepting the response at once
  task automatic doOne(input string tag, input logic [1:0] v, input logic [5:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] grant, input logic [3:0] res, input logic flg);
    applyStimulus(v, op, a, b, 2'b00);
    #1;
    checkOutput({tag, ".ready"}, 16'(req_ready), 16'(grant));
    tick();
    applyStimulus(2'b00, 6'd0, 8'd0, 8'd0, 2'b00);
    #1;
    checkOutput({tag, ".exec_busy"}, 16'(busy), 16'd1);
    checkOutput({tag, ".exec_rspv"}, 16'(rsp_valid), 16'd0);
    tick();
    #1;
    checkOutput({tag, ".rspv"}, 16'(rsp_valid), 16'(grant));
    checkOutput({tag, ".result"}, 16'(rsp_result), 16'(res));
    checkOutput({tag, ".flg"}, 16'(rsp_flg), 16'(flg));
    rsp_ready = grant;
    tick();
    rsp_ready = 2'b00;
    #1;
    checkOutput({tag, ".idle"}, 16'(busy), 16'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(2'b00, 6'd0, 8'd0, 8'd0, 2'b00);
    tick();
    tick();
    #1;
    checkOutput("rst.req_ready", 16'(req_ready), 16'd0);
    checkOutput("rst.rsp_valid", 16'(rsp_valid), 16'd0);
    checkOutput("rst.rsp_result", 16'(rsp_result), 16'd0);
    checkOutput("rst.rsp_flg", 16'(rsp_flg), 16'd0);
    checkOutput("rst.busy", 16'(busy), 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Requester 0 operations
    doOne("r0_add_wrap", 2'b01, {3'd0, 3'd0}, {4'h0, 4'h7}, {4'h0, 4'h9}, 2'b01, 4'h0, 1'b0);
    doOne("r0_sub",      2'b01, {3'd0, 3'd1}, {4'h0, 4'h3}, {4'h0, 4'h5}, 2'b01, 4'hE, 1'b0);
    doOne("r0_not",      2'b01, {3'd0, 3'd2}, {4'h0, 4'h5}, {4'h0, 4'h0}, 2'b01, 4'hA, 1'b0);
    doOne("r0_and",      2'b01, {3'd0, 3'd3}, {4'h0, 4'hC}, {4'h0, 4'hA}, 2'b01, 4'h8, 1'b0);
    doOne("r0_or",       2'b01, {3'd0, 3'd4}, {4'h0, 4'hC}, {4'h0, 4'hA}, 2'b01, 4'hE, 1'b0);
    doOne("r0_xor",      2'b01, {3'd0, 3'd5}, {4'h0, 4'hC}, {4'h0, 4'hA}, 2'b01, 4'h6, 1'b0);
    doOne("r0_slt_1_m8", 2'b01, {3'd0, 3'd6}, {4'h0, 4'h1}, {4'h0, 4'h8}, 2'b01, 4'h0, 1'b0);
    doOne("r0_slt_m8_7", 2'b01, {3'd0, 3'd6}, {4'h0, 4'h8}, {4'h0, 4'h7}, 2'b01, 4'h0, 1'b1);

    // Requester 1 compares
    doOne("r1_slt_m8_1", 2'b10, {3'd6, 3'd0}, {4'h8, 4'h0}, {4'h1, 4'h0}, 2'b10, 4'h0, 1'b1);
    doOne("r1_eq_5_5",   2'b10, {3'd7, 3'd0}, {4'h5, 4'h0}, {4'h5, 4'h0}, 2'b10, 4'h0, 1'b1);
    doOne("r1_eq_5_6",   2'b10, {3'd7, 3'd0}, {4'h5, 4'h0}, {4'h6, 4'h0}, 2'b10, 4'h0, 1'b0);

    // Both valid, responses accepted at once: grants alternate starting at 0
    applyStimulus(2'b11, {3'd1, 3'd1}, {4'h9, 4'h3}, {4'h2, 4'h5}, 2'b11);
    for (int i = 0; i < 4; i++) begin
      expGrant  = (i % 2 == 0) ? 2'b01 : 2'b10;
      expResult = (i % 2 == 0) ? 4'hE  : 4'h7;
      #1;
      checkOutput("rr.req_ready", 16'(req_ready), 16'(expGrant));
      tick();
      tick();
      #1;
      checkOutput("rr.rsp_valid", 16'(rsp_valid), 16'(expGrant));
      checkOutput("rr.result", 16'(rsp_result), 16'(expResult));
      tick();
    end
    applyStimulus(2'b00, 6'd0, 8'd0, 8'd0, 2'b00);
    tick();

    // Back-pressure: response held, non-owner rsp_ready ignored, waiters stalled
    applyStimulus(2'b01, {3'd0, 3'd0}, {4'h0, 4'h2}, {4'h0, 4'h3}, 2'b00);
    #1;
    checkOutput("bp.accept", 16'(req_ready), 16'b01);
    tick();
    applyStimulus(2'b11, {3'd0, 3'd0}, {4'h0, 4'h2}, {4'h0, 4'h3}, 2'b10);
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("bp.rsp_valid", 16'(rsp_valid), 16'b01);
      checkOutput("bp.result", 16'(rsp_result), 16'h5);
      checkOutput("bp.req_ready", 16'(req_ready), 16'b00);
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    #1;
    checkOutput("bp.release_busy", 16'(busy), 16'd0);
    checkOutput("bp.release_rspv", 16'(rsp_valid), 16'd0);
    checkOutput("bp.next_grant", 16'(req_ready), 16'b10);
    applyStimulus(2'b00, 6'd0, 8'd0, 8'd0, 2'b00);
    tick();

    // Reset during EXEC discards the op and restores the pointer to 0
    applyStimulus(2'b01, {3'd0, 3'd0}, {4'h0, 4'h1}, {4'h0, 4'h1}, 2'b00);
    tick();
    applyStimulus(2'b00, 6'd0, 8'd0, 8'd0, 2'b11);
    #1;
    checkOutput("mid.exec_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid.busy", 16'(busy), 16'd0);
    checkOutput("mid.req_ready", 16'(req_ready), 16'd0);
    checkOutput("mid.rsp_valid", 16'(rsp_valid), 16'd0);
    checkOutput("mid.rsp_result", 16'(rsp_result), 16'd0);
    checkOutput("mid.rsp_flg", 16'(rsp_flg), 16'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checkOutput("mid.no_rsp", 16'(rsp_valid), 16'd0);
      checkOutput("mid.idle", 16'(busy), 16'd0);
    end
    applyStimulus(2'b11, 6'd0, 8'd0, 8'd0, 2'b00);
    #1;
    checkOutput("mid.rr_reset", 16'(req_ready), 16'b01);
    applyStimulus(2'b00, 6'd0, 8'd0, 8'd0, 2'b00);
    tick();

`ifdef ALU_ARB_STATS_EN
    #1;
    checkOutput("stats.cnt0_rst", 16'(grant_cnt0), 16'd0);
    checkOutput("stats.cnt1_rst", 16'(grant_cnt1), 16'd0);
    applyStimulus(2'b01, {3'd0, 3'd0}, {4'h0, 4'h1}, {4'h0, 4'h1}, 2'b01);
    repeat (900) tick();
    applyStimulus(2'b00, 6'd0, 8'd0, 8'd0, 2'b00);
    #1;
    checkOutput("stats.cnt0_sat", 16'(grant_cnt0), 16'd255);
    checkOutput("stats.cnt1", 16'(grant_cnt1), 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
